// File: rtl/shifter_arbiter.sv
// Round-robin arbiter in front of a shared multi-step shift/rotate datapath.
// Define SHIFTER_ARB_ONECYCLE_EN to run the whole shift in one cycle through a barrel network.
module shifter_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ*2-1:0]         req_op,
    input  logic [NREQ*AW-1:0]        req_amt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] rd [NREQ];
    logic [1:0]       ro [NREQ];
    logic [AW-1:0]    ra [NREQ];
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic             found;

    // Shift/rotate by n positions; rotates wrap mod WIDTH, logical right saturates to zero.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       op,
                                                  input int unsigned      n);
        int unsigned m;
        m = n % WIDTH;
        case (op)
            2'b01:   shift_by = (d << m) | (d >> (WIDTH - m));
            2'b10:   shift_by = (d >> m) | (d << (WIDTH - m));
            2'b11:   shift_by = d >> n;
            default: shift_by = d;
        endcase
    endfunction

`ifdef SHIFTER_ARB_ONECYCLE_EN
    // One power-of-two stage per amount bit gives a log-depth network.
    function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input logic [AW-1:0]    amt);
        logic [WIDTH-1:0] r;
        logic [AW-1:0]    a;
        r = d;
        a = amt;
        for (int s = 0; s < int'(AW); s++) begin
            if (a[0]) r = shift_by(r, op, 32'd1 << s);
            a = a >> 1;
        end
        barrel = r;
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            rd[i] = req_data[i*WIDTH +: WIDTH];
            ro[i] = req_op[i*2 +: 2];
            ra[i] = req_amt[i*AW +: AW];
        end
    end

    // Scan from the far end back to ptr so the first valid after ptr wins.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    data_d  = rd[win];
                    op_d    = ro[win];
                    cnt_d   = ra[win];
                    id_d    = win;
                    state_d = (ra[win] != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
`ifdef SHIFTER_ARB_ONECYCLE_EN
                data_d  = barrel(data_q, op_q, cnt_q);
                cnt_d   = '0;
                state_d = S_DONE;
`else
                data_d = shift_by(data_q, op_q, 32'd1);
                if (cnt_q != '0) cnt_d = cnt_q - AW'(1);
                if (cnt_q <= AW'(1)) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed plus randomized bench for shifter_arbiter against an arithmetic reference model.
// Honors SHIFTER_ARB_ONECYCLE_EN for the expected latency.
module tb_shifter_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data = '0;
    logic [N*2-1:0]  req_op = '0;
    logic [N*AW-1:0] req_amt = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [W-1:0]    rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;
    int sd [N];
    int so [N];
    int sa [N];
    logic [31:0] last_data;
    logic [31:0] last_id;
    int w;

    shifter_arbiter #(.NREQ(N), .WIDTH(W), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of the whole operation from plain arithmetic on the integer value.
    function automatic int model(input int d, input int op, input int amt);
        int m;
        m = amt % W;
        case (op)
            1:       return (d * (1 << m) + d / (1 << (W - m))) % (1 << W);
            2:       return d / (1 << m) + (d % (1 << m)) * (1 << (W - m));
            3:       return (amt >= W) ? 0 : d / (1 << amt);
            default: return d;
        endcase
    endfunction

    function automatic int latency(input int amt);
`ifdef SHIFTER_ARB_ONECYCLE_EN
        return (amt != 0) ? 2 : 1;
`else
        return 1 + amt;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_slot(input int i, input int d, input int op, input int amt);
        sd[i] = d; so[i] = op; sa[i] = amt;
        req_data[i*W +: W] = W'(d);
        req_op[i*2 +: 2]   = 2'(op);
        req_amt[i*AW +: AW] = AW'(amt);
    endtask

    // One full job: arbitration, latency, hold under stall, handshake. Called #1 after an edge.
    task automatic serve(input logic [N-1:0] mask, input int stall, output int win);
        int edges;
        int exp_d;
        int exp_lat;
        win = pick(mask);
        exp_d = model(sd[win], so[win], sa[win]);
        exp_lat = latency(sa[win]);
        rsp_ready = (stall == 0);
        req_valid = mask;
        #1;
        check("grant", 32'(req_ready), 32'(1 << win));
        edges = 0;
        do begin
            @(posedge clk); edges++; #1;
            if (!rsp_valid) begin
                check("busy_during", 32'(busy), 1);
                check("ready_busy", 32'(req_ready), 0);
            end
        end while (!rsp_valid && edges < 40);
        check("latency", edges, exp_lat);
        check("rsp_data", 32'(rsp_data), exp_d);
        check("rsp_id", 32'(rsp_id), win);
        last_data = 32'(rsp_data);
        last_id   = 32'(rsp_id);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_data", 32'(rsp_data), exp_d);
            check("stall_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(rsp_valid), 0);
        check("post_busy", 32'(busy), 0);
        ptr = (win + 1) % N;
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_slot(i, 0, 0, 0);
        #3;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_data", 32'(rsp_data), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Everyone requesting with zero-step passes: strict rotation from requester 0.
        set_slot(0, 5, 0, 0); set_slot(1, 10, 0, 0); set_slot(2, 12, 0, 0); set_slot(3, 3, 0, 0);
        for (int g = 0; g < 5; g++) begin
            serve(4'b1111, 0, w);
            check("rr_order", last_id, g % N);
        end
        check("rr_data0", last_data, 5);

        set_slot(0, 4'b1001, 1, 1);
        serve(4'b0001, 0, w);
        check("t1_data", last_data, 4'b0011);
        check("t1_id", last_id, 0);

        set_slot(2, 4'b1000, 2, 3);
        serve(4'b0100, 0, w);
        check("t2_data", last_data, 4'b0001);

        set_slot(1, 4'b1111, 3, 3);
        serve(4'b0010, 5, w);
        check("t4_data", last_data, 4'b0001);

        // Reset while shifting a three-step job; the pointer must return to requester 0.
        set_slot(2, 4'b0110, 1, 3);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("arst_valid", 32'(rsp_valid), 0);
        check("arst_data", 32'(rsp_data), 0);
        check("arst_id", 32'(rsp_id), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(req_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ptr = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("no_stale", 32'(rsp_valid), 0);
        end
        serve(4'b1111, 0, w);
        check("ptr_reset", last_id, 0);

        set_slot(3, 4'b0001, 1, 3);
        serve(4'b1000, 0, w);
        check("rotl3", last_data, 4'b1000);

        for (int it = 0; it < 60; it++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++)
                set_slot(i, int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(3)));
            m = N'($urandom_range(15));
            if (m == '0) begin
                req_valid = '0;
                #1;
                check("idle_ready", 32'(req_ready), 0);
                @(posedge clk); #1;
                check("idle_busy", 32'(busy), 0);
            end else begin
                serve(m, int'($urandom_range(2)), w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one multi-step shift/rotate datapath between NREQ requesters using round-robin arbitration.
- Each request carries data, an operation and a step count. The block executes one single-position step per cycle, then returns the result with the requester ID.
- Sits between requesting engines and downstream consumers; it owns the datapath registers and the sequencing FSM.

Parameters:
- NREQ, 4, number of requesters (legal 2..8)
- WIDTH, 4, data width in bits (legal 2..16)
- AW, 2, step-count width; max steps = 2**AW-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_data  in  NREQ*WIDTH  packed operand, requester i at [i*WIDTH +: WIDTH]
- req_op  in  NREQ*2  packed op: 00 pass, 01 rotate left, 10 rotate right, 11 logical shift right (zero fill)
- req_amt  in  NREQ*AW  packed step count
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_data  out  WIDTH  result
- rsp_id  out  clog2(NREQ)  index of the requester served
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0, rr pointer=0 (requester 0 highest priority).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational. It asserts for the single winner only.
  - Winner = first valid index scanning ptr, ptr+1, ... modulo NREQ.
  - On accept, latch data, op, amt and id.
  - amt!=0 -> SHIFT; amt==0 -> DONE.
  - No valid -> stay in IDLE.
- SHIFT: each cycle apply one step to the data register and decrement count.
  - The cycle the count reaches 0 -> DONE.
- Step definitions:
  - 01: {d[W-2:0], d[W-1]}
  - 10: {d[0], d[W-1:1]}
  - 11: {1'b0, d[W-1:1]}
  - 00: unchanged, but steps are still counted (the latency contract holds).
- DONE: rsp_valid=1. rsp_data and rsp_id are held stable until rsp_valid && rsp_ready.
  - On handshake: ptr <= id+1 (wraps NREQ-1 -> 0), rsp_valid drops next cycle, -> IDLE.
- Latency: request accepted at edge T -> rsp_valid high after edge T+1+amt.
- Throughput: the earliest next accept is the cycle after the response handshake, because IDLE is revisited. req_ready is never high outside IDLE.
- Requesters must hold valid, data, op and amt until their req_ready. Dropping valid before grant is legal and simply removes the requester from arbitration.
- Fairness: a continuously requesting port waits at most NREQ-1 services.
- rsp_ready low in DONE: stall indefinitely, no state change, no new accepts.
- Async reset mid-SHIFT or mid-DONE: the job is discarded, all outputs return to reset values immediately, and no response is emitted.
- Widths: count wraps never (decrement only while nonzero). Op 11 with amt>=WIDTH yields 0.

Optional Feature:
- Macro SHIFTER_ARB_ONECYCLE_EN.
- Defined:
  - SHIFT state executes the full amt-position operation in one cycle using a log-depth barrel network.
  - Rotate amounts are taken mod WIDTH; shift-right fills with zeros and saturates to 0.
  - Latency is fixed: rsp_valid after edge T+2 when amt!=0, and T+1 when amt==0.
- Undefined: one position per cycle as described above.
- Results are identical in both builds; only timing differs.

Test Plan:
- Reset, then NREQ=4 req0 data=4'b1001 op=01 amt=1 -> req_ready[0] one cycle; rsp_valid after 2 edges; rsp_data=4'b0011, rsp_id=0.
- req2 data=4'b1000 op=10 amt=3, rsp_ready=1 -> rsp_data=4'b0001 exactly 4 edges after accept; busy high for the whole interval.
- All four valid continuously, each amt=0 op=00 -> grants in order 0,1,2,3,0; each rsp_data equals its input.
- req1 op=11 data=4'b1111 amt=3 with rsp_ready=0 for 5 cycles -> rsp_data=4'b0001 held stable, req_ready all zero; accept completes when rsp_ready=1.
- Assert rst_n=0 during SHIFT of an amt=3 job -> outputs zero immediately; after release, ptr=0 and no stale rsp_valid.
- With SHIFTER_ARB_ONECYCLE_EN: op=01 data=4'b0001 amt=3 -> rsp_data=4'b1000 after 2 edges.
